// File: rtl/hpc2_rnd_feeder.sv
`default_nettype none
// ============================================================================
// Module   : hpc2_rnd_feeder
// Brief    : Collects IN_W-bit PRNG chunks into RW-bit randomness words for
//            NGADGETS parallel HPC2 gadgets (d shares each) and presents each
//            word exactly once on a valid/ready output.
//            Optional macro HPC2_RND_FEEDER_DOUBLE_BUF_EN adds a fill buffer
//            separate from the output register for full throughput.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module hpc2_rnd_feeder #(
  parameter int d        = `DEFAULTSHARES,
  parameter int NGADGETS = 4,
  parameter int IN_W     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [IN_W-1:0]                    in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [NGADGETS*d*(d-1)/2-1:0]      rnd_out,
  output logic                               rnd_valid,
  input  logic                               rnd_ready
);

  localparam int RW = NGADGETS * d * (d - 1) / 2;
  localparam int C  = (IN_W > 0) ? RW / IN_W : 0;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0] LAST = CW'(C - 1);

  // Reject configurations where chunks cannot tile the word exactly.
  generate
    if (RW == 0 || IN_W <= 0 || (RW % IN_W) != 0) begin : g_bad_cfg
      $error("hpc2_rnd_feeder: RW must be non-zero and a multiple of IN_W");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [RW-1:0] fill_buf;
  logic [RW-1:0] out_reg;
  logic [RW-1:0] word;
  logic          in_fire;
  logic          out_fire;
  logic          last_fire;

  // Current fill buffer with the incoming chunk merged into its slot.
  always_comb begin
    word = fill_buf;
    word[cnt*IN_W +: IN_W] = in_data;
  end

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = rnd_valid && rnd_ready;
  assign last_fire = in_fire && (cnt == LAST);
  assign rnd_out   = out_reg;

`ifdef HPC2_RND_FEEDER_DOUBLE_BUF_EN

  logic buf_full;
  logic out_valid;

  // A completed buffer only waits here while the output still holds a word.
  assign in_ready  = !(buf_full && out_valid);
  assign rnd_valid = out_valid;

  // Chunk collection, buffer hand-over and output consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      fill_buf  <= '0;
      buf_full  <= 1'b0;
      out_reg   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        if (last_fire) begin
          cnt      <= '0;
          fill_buf <= '0;
        end else begin
          cnt      <= cnt + CW'(1);
          fill_buf <= word;
        end
      end

      if (buf_full && out_fire) begin
        // Waiting word replaces the consumed one; valid stays high.
        out_reg  <= fill_buf;
        fill_buf <= '0;
        buf_full <= 1'b0;
      end else if (last_fire && (!out_valid || out_fire)) begin
        out_reg   <= word;
        out_valid <= 1'b1;
      end else if (last_fire) begin
        // Output occupied and not consumed: park the word in the fill buffer.
        fill_buf <= word;
        buf_full <= 1'b1;
      end else if (out_fire) begin
        out_reg   <= '0;
        out_valid <= 1'b0;
      end
    end
  end

`else

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0] state;

  assign in_ready  = (state == S_FILL);
  assign rnd_valid = (state == S_FULL);

  // Two-state FILL/FULL machine sharing one output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FILL;
      cnt      <= '0;
      fill_buf <= '0;
      out_reg  <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (last_fire) begin
            cnt      <= '0;
            fill_buf <= '0;
            out_reg  <= word;
            state    <= S_FULL;
          end else if (in_fire) begin
            cnt      <= cnt + CW'(1);
            fill_buf <= word;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            out_reg <= '0;
            state   <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

`endif

endmodule

`default_nettype wire

// File: tb/tb_hpc2_rnd_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpc2_rnd_feeder
// Brief    : Directed, table-driven bench for hpc2_rnd_feeder (d=3,
//            NGADGETS=2, IN_W=2) plus a C=1 instance (IN_W=6) for streaming.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpc2_rnd_feeder;

`ifdef HPC2_RND_FEEDER_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] rnd_out;
  logic       rnd_valid;
  logic       rnd_ready = 1'b0;

  logic [5:0] c1_data = '0;
  logic       c1_valid = 1'b0;
  logic       c1_in_ready;
  logic [5:0] c1_out;
  logic       c1_rvalid;
  logic       c1_rready = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hpc2_rnd_feeder #(.d(3), .NGADGETS(2), .IN_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rnd_out(rnd_out), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready)
  );

  hpc2_rnd_feeder #(.d(3), .NGADGETS(2), .IN_W(6)) dut_c1 (
    .clk(clk), .rst(rst), .in_data(c1_data), .in_valid(c1_valid),
    .in_ready(c1_in_ready), .rnd_out(c1_out), .rnd_valid(c1_rvalid),
    .rnd_ready(c1_rready)
  );

  typedef struct packed {
    logic       iv;
    logic [1:0] din;
    logic       rr;
    logic       ev;
    logic       rdy_sb;
    logic       rdy_db;
    logic [5:0] eout;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk3(input string nm, input logic ev, input logic er, input logic [5:0] eo);
    chk({nm, ".rnd_valid"}, {31'd0, rnd_valid}, {31'd0, ev});
    chk({nm, ".in_ready"},  {31'd0, in_ready},  {31'd0, er});
    chk({nm, ".rnd_out"},   {26'd0, rnd_out},   {26'd0, eo});
  endtask

  // Drive inputs just after an edge, then sample just after the next edge.
  task automatic step(input logic iv, input logic [1:0] din, input logic rr);
    in_valid  = iv;
    in_data   = din;
    rnd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
    tbl[1] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
    tbl[2] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 6'b111001};
    tbl[3] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 6'b111001};
    tbl[4] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000000};
    tbl[5] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000000};
    tbl[6] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000000};
    tbl[7] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
    tbl[8] = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 6'b011111};
    tbl[9] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 6'b000000};

    // Reset held for two cycles.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk3("reset", 1'b0, 1'b1, 6'b000000);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].iv, tbl[i].din, tbl[i].rr);
      chk3($sformatf("vec%0d", i), tbl[i].ev, DB ? tbl[i].rdy_db : tbl[i].rdy_sb, tbl[i].eout);
    end

    // Reset in the middle of a word discards the partial chunks.
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    chk3("midfill.pre", 1'b0, 1'b1, 6'b000000);
    rst = 1'b1;
    step(1'b0, 2'b00, 1'b0);
    chk3("midfill.rst", 1'b0, 1'b1, 6'b000000);
    rst = 1'b0;
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    chk3("midfill.c1", 1'b0, 1'b1, 6'b000000);
    step(1'b1, 2'b10, 1'b0);
    chk3("midfill.word", 1'b1, DB, 6'b100011);
    step(1'b0, 2'b00, 1'b1);
    chk3("midfill.consume", 1'b0, 1'b1, 6'b000000);

`ifdef HPC2_RND_FEEDER_DOUBLE_BUF_EN
    // Second word queues behind the held output.
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    chk3("db.first", 1'b1, 1'b1, 6'b111001);
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    chk3("db.partial", 1'b1, 1'b1, 6'b111001);
    step(1'b1, 2'b01, 1'b0);
    chk3("db.bufcomplete", 1'b1, 1'b0, 6'b111001);
    step(1'b1, 2'b11, 1'b0);
    chk3("db.stall", 1'b1, 1'b0, 6'b111001);
    step(1'b0, 2'b00, 1'b1);
    chk3("db.handover", 1'b1, 1'b1, 6'b011100);
    step(1'b0, 2'b00, 1'b1);
    chk3("db.drain", 1'b0, 1'b1, 6'b000000);
`else
    // Chunks offered while FULL must be ignored.
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    chk3("sb.full", 1'b1, 1'b0, 6'b111001);
    step(1'b1, 2'b11, 1'b0);
    chk3("sb.ignore", 1'b1, 1'b0, 6'b111001);
    step(1'b1, 2'b11, 1'b1);
    chk3("sb.consume", 1'b0, 1'b1, 6'b000000);
`endif
    // Next word must start at chunk 0 with no stray chunk absorbed.
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    chk3("after.partial", 1'b0, 1'b1, 6'b000000);
    step(1'b1, 2'b01, 1'b0);
    chk3("after.word", 1'b1, DB, 6'b010101);
    step(1'b0, 2'b00, 1'b1);
    chk3("after.consume", 1'b0, 1'b1, 6'b000000);
    step(1'b0, 2'b00, 1'b0);

    // C=1 streaming: data i+1 offered on cycle i, ready held high.
    for (int i = 0; i < 16; i++) begin
      c1_valid  = 1'b1;
      c1_rready = 1'b1;
      c1_data   = 6'(i + 1);
      @(posedge clk);
      #1;
      if (DB || (i % 2 == 0)) begin
        chk($sformatf("c1.valid%0d", i), {31'd0, c1_rvalid}, 32'd1);
        chk($sformatf("c1.out%0d", i),   {26'd0, c1_out},    32'(i + 1));
      end else begin
        chk($sformatf("c1.valid%0d", i), {31'd0, c1_rvalid}, 32'd0);
        chk($sformatf("c1.out%0d", i),   {26'd0, c1_out},    32'd0);
      end
    end
    c1_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("c1.drain", {31'd0, c1_rvalid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
